// File: rtl/countdown_timer.sv
// HH:MM:SS down-counter with preset load, start/pause control, done pulse and alarm level.
// Time fields decrement once per T_HOLD cycles while running; number is packed decimal H*10000+M*100+S.
module countdown_timer #(
  parameter int T_HOLD       = 100_000_000,
  parameter int T_HOLD_WIDTH = $clog2(T_HOLD)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [7:0]  load_hours,
  input  logic [7:0]  load_minutes,
  input  logic [7:0]  load_seconds,
  input  logic        start,
  input  logic        pause,
  output logic [23:0] number,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              h_q, m_q, s_q;
  logic [7:0]              h_d, m_d, s_d;
  logic [T_HOLD_WIDTH-1:0] presc_q, presc_d;
  logic                    done_q, done_d;
  logic                    is_zero;
  logic                    sec_tick;

  assign is_zero  = (h_q == 8'd0) && (m_q == 8'd0) && (s_q == 8'd0);
  assign sec_tick = (presc_q == T_HOLD_WIDTH'(T_HOLD - 1));

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    m_d     = m_q;
    s_d     = s_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    // load overrides everything else, including a same-cycle start
    if (load) begin
      h_d     = (load_hours   > 8'd23) ? 8'd23 : load_hours;
      m_d     = (load_minutes > 8'd59) ? 8'd59 : load_minutes;
      s_d     = (load_seconds > 8'd59) ? 8'd59 : load_seconds;
      presc_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !is_zero) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (sec_tick) begin
            presc_d = '0;
            if (s_q != 8'd0) begin
              s_d = s_q - 8'd1;
            end else if (m_q != 8'd0) begin
              m_d = m_q - 8'd1;
              s_d = 8'd59;
            end else if (h_q != 8'd0) begin
              h_d = h_q - 8'd1;
              m_d = 8'd59;
              s_d = 8'd59;
            end
            if ((h_d == 8'd0) && (m_d == 8'd0) && (s_d == 8'd0)) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + T_HOLD_WIDTH'(1);
          end
        end
        PAUSED: begin
          if (start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      h_q     <= 8'd0;
      m_q     <= 8'd0;
      s_q     <= 8'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      m_q     <= m_d;
      s_q     <= s_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign number  = ({16'd0, h_q} * 24'd10000) + ({16'd0, m_q} * 24'd100) + {16'd0, s_q};
  assign running = (state_q == RUN);
  assign alarm   = (state_q == EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with T_HOLD=4: load/clamp vector table plus hand-timed sequences.
module tb_countdown_timer;

  localparam int TH = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  load_hours;
  logic [7:0]  load_minutes;
  logic [7:0]  load_seconds;
  logic        start;
  logic        pause;
  logic [23:0] number;
  logic        running;
  logic        done;
  logic        alarm;

  int n_cmp;
  int n_bad;

  countdown_timer #(.T_HOLD(TH), .T_HOLD_WIDTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_hours   (load_hours),
    .load_minutes (load_minutes),
    .load_seconds (load_seconds),
    .start        (start),
    .pause        (pause),
    .number       (number),
    .running      (running),
    .done         (done),
    .alarm        (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  h;
    logic [7:0]  m;
    logic [7:0]  s;
    logic [23:0] exp_number;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the pulse is sampled by the next posedge.
  task automatic pulse(input logic l, input logic st, input logic p);
    load  = l;
    start = st;
    pause = p;
    @(negedge clk);
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic set_preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hours   = h;
    load_minutes = m;
    load_seconds = s;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    set_preset(8'd0, 8'd0, 8'd0);

    vecs[0] = '{8'd99,  8'd99, 8'd99, 24'd235959};
    vecs[1] = '{8'd12,  8'd34, 8'd56, 24'd123456};
    vecs[2] = '{8'd23,  8'd59, 8'd59, 24'd235959};
    vecs[3] = '{8'd24,  8'd60, 8'd60, 24'd235959};
    vecs[4] = '{8'd0,   8'd99, 8'd5,  24'd5905};
    vecs[5] = '{8'd255, 8'd0,  8'd0,  24'd230000};
    vecs[6] = '{8'd7,   8'd8,  8'd60, 24'd70859};
    vecs[7] = '{8'd0,   8'd0,  8'd0,  24'd0};

    #2;
    check("reset_number",  32'(number),  32'd0);
    check("reset_running", 32'(running), 32'd0);
    check("reset_done",    32'(done),    32'd0);
    check("reset_alarm",   32'(alarm),   32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // Load / clamp table
    for (int i = 0; i < 8; i++) begin
      set_preset(vecs[i].h, vecs[i].m, vecs[i].s);
      pulse(1'b1, 1'b0, 1'b0);
      check($sformatf("load_number[%0d]", i), 32'(number), 32'(vecs[i].exp_number));
      check($sformatf("load_running[%0d]", i), 32'(running), 32'd0);
    end

    // Start on a zero preset is ignored
    pulse(1'b0, 1'b1, 1'b0);
    check("zero_start_running", 32'(running), 32'd0);
    tick(5);
    check("zero_start_running_later", 32'(running), 32'd0);

    // 00:00:03 countdown to expiry
    set_preset(8'd0, 8'd0, 8'd3);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("run_running", 32'(running), 32'd1);
    tick(3);
    check("run_c3", 32'(number), 32'd3);
    tick(1);
    check("run_c4", 32'(number), 32'd2);
    tick(4);
    check("run_c8", 32'(number), 32'd1);
    tick(3);
    check("run_c11_done", 32'(done), 32'd0);
    tick(1);
    check("run_c12_number", 32'(number), 32'd0);
    check("run_c12_done",   32'(done),   32'd1);
    check("run_c12_alarm",  32'(alarm),  32'd1);
    tick(1);
    check("run_c13_done",    32'(done),    32'd0);
    check("run_c13_alarm",   32'(alarm),   32'd1);
    check("run_c13_running", 32'(running), 32'd0);

    // EXPIRED ignores start, load clears alarm
    pulse(1'b0, 1'b1, 1'b0);
    check("exp_start_running", 32'(running), 32'd0);
    check("exp_start_alarm",   32'(alarm),   32'd1);
    set_preset(8'd0, 8'd0, 8'd7);
    pulse(1'b1, 1'b0, 1'b0);
    check("exp_load_alarm",  32'(alarm),  32'd0);
    check("exp_load_number", 32'(number), 32'd7);

    // Borrow chain through hours
    set_preset(8'd1, 8'd0, 8'd0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    tick(3);
    check("borrow_c3", 32'(number), 32'd10000);
    tick(1);
    check("borrow_c4", 32'(number), 32'd5959);
    tick(4);
    check("borrow_c8", 32'(number), 32'd5958);

    // Pause with prescaler at 2, resume finishes the remaining 2 cycles
    set_preset(8'd0, 8'd0, 8'd10);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    tick(2);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause_running", 32'(running), 32'd0);
    tick(20);
    check("pause_hold_number", 32'(number), 32'd10);
    pulse(1'b0, 1'b0, 1'b1);
    check("pause_pause_ignored", 32'(running), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("resume_running", 32'(running), 32'd1);
    tick(1);
    check("resume_c1", 32'(number), 32'd10);
    tick(1);
    check("resume_c2", 32'(number), 32'd9);

    // pause+start together in RUN -> paused
    pulse(1'b0, 1'b1, 1'b1);
    check("pause_start_running", 32'(running), 32'd0);
    tick(6);
    check("pause_start_number", 32'(number), 32'd9);
    pulse(1'b0, 1'b1, 1'b0);

    // load+start together in RUN -> IDLE with new value
    set_preset(8'd0, 8'd1, 8'd0);
    pulse(1'b1, 1'b1, 1'b0);
    check("load_start_running", 32'(running), 32'd0);
    check("load_start_number",  32'(number),  32'd100);
    tick(6);
    check("load_start_idle_hold", 32'(number), 32'd100);
    pulse(1'b0, 1'b1, 1'b0);
    check("restart_running", 32'(running), 32'd1);
    tick(4);
    check("restart_c4", 32'(number), 32'd59);

    // Asynchronous reset mid-RUN, observed before any clock edge
    tick(1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_number",  32'(number),  32'd0);
    check("async_rst_running", 32'(running), 32'd0);
    check("async_rst_alarm",   32'(alarm),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    check("post_rst_running", 32'(running), 32'd0);
    check("post_rst_number",  32'(number),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
